// File: rtl/wb_arbiter.sv
// Two-requester register-file write arbiter with starvation guard for requester 1,
// a one-cycle registered write port and a pending-write scoreboard.
module wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rf_w_en,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_w_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [31:0] sb_busy
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_next_s;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        xfer_s;
    logic [4:0]  sel_rd_s;
    logic [31:0] sel_data_s;
    logic        rf_w_en_r;
    logic [4:0]  rf_rd_r;
    logic [31:0] rf_w_data_r;
    logic [31:0] sb_busy_r;
    logic [31:0] sb_next_s;
    logic [31:0] sb_set_s;
    logic [31:0] sb_clr_s;

    // Grant selection: requester 0 has priority until requester 1 has lost STARVE_MAX times in a row.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (starve_cnt_r == STARVE_LIM) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (req0_valid) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Starvation counter next value: saturating count of consecutive losses by requester 1.
    always_comb begin
        starve_next_s = starve_cnt_r;
        if (!req1_valid || gnt1_s) begin
            starve_next_s = 4'd0;
        end else if (starve_cnt_r < STARVE_LIM) begin
            starve_next_s = starve_cnt_r + 4'd1;
        end else begin
            starve_next_s = starve_cnt_r;
        end
    end

    assign xfer_s     = gnt0_s | gnt1_s;
    assign sel_rd_s   = gnt1_s ? req1_rd : req0_rd;
    assign sel_data_s = gnt1_s ? req1_data : req0_data;

    // Set beats clear on the same bit because the newer producer is still outstanding.
    assign sb_clr_s  = rf_w_en_r ? (32'd1 << rf_rd_r) : 32'd0;
    assign sb_set_s  = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    assign sb_next_s = ((sb_busy_r & ~sb_clr_s) | sb_set_s) & ~32'd1;

    // State registers: starvation counter, write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
            rf_w_en_r    <= 1'b0;
            rf_rd_r      <= 5'd0;
            rf_w_data_r  <= 32'd0;
            sb_busy_r    <= 32'd0;
        end else begin
            starve_cnt_r <= starve_next_s;
            sb_busy_r    <= sb_next_s;
            if (xfer_s) begin
                rf_w_en_r   <= (sel_rd_s != 5'd0);
                rf_rd_r     <= sel_rd_s;
                rf_w_data_r <= sel_data_s;
            end else begin
                rf_w_en_r   <= 1'b0;
            end
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign rf_w_en    = rf_w_en_r;
    assign rf_rd      = rf_rd_r;
    assign rf_w_data  = rf_w_data_r;
    assign sb_busy    = sb_busy_r;
    assign rs1_busy   = (rs1 != 5'd0) && sb_busy_r[rs1];
    assign rs2_busy   = (rs2 != 5'd0) && sb_busy_r[rs2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: grants, starvation, write port, scoreboard, reset.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rf_w_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_w_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] sb_busy;

    int n_chk;
    int n_fail;

    wb_arbiter #(.STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .sb_busy(sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks happen 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h1234_5678;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h8765_4321;
        issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        step(); step(); #1;
        n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b expected 0", req0_ready); end
        n_chk++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b expected 0", req1_ready); end
        n_chk++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_w_en: got %b expected 0", rf_w_en); end
        n_chk++; if (rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rf_rd: got %0d expected 0", rf_rd); end
        n_chk++; if (rf_w_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_w_data: got %h expected 0", rf_w_data); end
        n_chk++; if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL reset_sb_busy: got %h expected 0", sb_busy); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_req0_ready: got %b expected 1", req0_ready); end
        n_chk++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_req1_ready: got %b expected 0", req1_ready); end
        step();
        req0_valid = 1'b0;
        #1;
        n_chk++; if (rf_w_en !== 1'b1) begin n_fail++; $display("FAIL single_rf_w_en: got %b expected 1", rf_w_en); end
        n_chk++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL single_rf_rd: got %0d expected 5", rf_rd); end
        n_chk++; if (rf_w_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rf_w_data: got %h expected deadbeef", rf_w_data); end
        n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL idle_req0_ready: got %b expected 0", req0_ready); end
        step(); #1;
        n_chk++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL single_idle_rf_w_en: got %b expected 0", rf_w_en); end
        n_chk++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL single_hold_rf_rd: got %0d expected 5", rf_rd); end
        n_chk++; if (rf_w_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold_rf_w_data: got %h expected deadbeef", rf_w_data); end
    endtask

    task automatic test_req1_only();
        step();
        req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'h0000_0B0B;
        #1;
        n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL req1only_ready: got %b expected 1", req1_ready); end
        n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL req1only_req0_ready: got %b expected 0", req0_ready); end
        step();
        req1_valid = 1'b0;
        #1;
        n_chk++; if ({rf_w_en, rf_rd, rf_w_data} !== {1'b1, 5'd11, 32'h0000_0B0B}) begin
            n_fail++; $display("FAIL req1only_rf: got en=%b rd=%0d data=%h expected en=1 rd=11 data=00000b0b", rf_w_en, rf_rd, rf_w_data);
        end
    endtask

    // Both valid every cycle: expected grant pattern 0,0,0,1,0 and one write per cycle.
    task automatic test_back_to_back();
        logic [4:0] exp_grant;
        logic [4:0] prev_rd;
        logic [31:0] prev_data;
        exp_grant = 5'b01000;
        prev_rd = 5'd0;
        prev_data = 32'd0;
        req1_rd = 5'd20; req1_data = 32'hAAAA_0020;
        for (int i = 0; i < 5; i++) begin
            step();
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_rd = 5'(10 + i); req0_data = 32'hC000_0000 + 32'(i);
            #1;
            n_chk++; if (req1_ready !== exp_grant[i] || req0_ready !== !exp_grant[i]) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got r0=%b r1=%b expected r1=%b", i, req0_ready, req1_ready, exp_grant[i]);
            end
            if (i > 0) begin
                n_chk++; if ({rf_w_en, rf_rd, rf_w_data} !== {1'b1, prev_rd, prev_data}) begin
                    n_fail++; $display("FAIL b2b_rf[%0d]: got en=%b rd=%0d data=%h expected en=1 rd=%0d data=%h", i, rf_w_en, rf_rd, rf_w_data, prev_rd, prev_data);
                end
            end
            prev_rd   = exp_grant[i] ? req1_rd : req0_rd;
            prev_data = exp_grant[i] ? req1_data : req0_data;
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_x0_filter();
        step();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_valid = 1'b0;
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_CAFE;
        #1;
        n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", req1_ready); end
        n_chk++; if (sb_busy !== 32'h0000_0008) begin n_fail++; $display("FAIL x0_sb_before: got %h expected 00000008", sb_busy); end
        step();
        req1_valid = 1'b0;
        #1;
        n_chk++; if ({rf_w_en, rf_rd, rf_w_data} !== {1'b0, 5'd0, 32'h0000_CAFE}) begin
            n_fail++; $display("FAIL x0_rf: got en=%b rd=%0d data=%h expected en=0 rd=0 data=0000cafe", rf_w_en, rf_rd, rf_w_data);
        end
        step(); #1;
        n_chk++; if (sb_busy !== 32'h0000_0008) begin n_fail++; $display("FAIL x0_sb_after: got %h expected 00000008", sb_busy); end
        // Retire r3 so later scoreboard checks start clean.
        step();
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h3;
        step();
        req0_valid = 1'b0;
        step(); #1;
        n_chk++; if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL x0_sb_retire: got %h expected 0", sb_busy); end
    endtask

    task automatic test_scoreboard();
        step();                     // T
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd0;
        #1;
        n_chk++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass: got %b expected 0", rs1_busy); end
        step();                     // T+1
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        n_chk++; if (sb_busy[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set7: got %b expected 1", sb_busy[7]); end
        n_chk++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_rs1_busy: got %b expected 1", rs1_busy); end
        n_chk++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_rs2_zero: got %b expected 0", rs2_busy); end
        step();                     // T+2
        issue_valid = 1'b0; rs2 = 5'd7;
        #1;
        n_chk++; if (sb_busy !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_x0_never_set: got %h expected 00000080", sb_busy); end
        n_chk++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL sb_rs2_busy: got %b expected 1", rs2_busy); end
        step();                     // T+3
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h0000_0077;
        #1;
        n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL sb_wr_ready: got %b expected 1", req0_ready); end
        step();                     // T+4
        req0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd12;
        #1;
        n_chk++; if ({rf_w_en, rf_rd} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL sb_wr_rf: got en=%b rd=%0d expected en=1 rd=7", rf_w_en, rf_rd); end
        n_chk++; if (sb_busy[7] !== 1'b1) begin n_fail++; $display("FAIL sb_still_busy: got %b expected 1", sb_busy[7]); end
        step();                     // T+5
        issue_valid = 1'b0;
        #1;
        n_chk++; if (sb_busy !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_clr7_set12: got %h expected 00001000", sb_busy); end
        n_chk++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_rs1_free: got %b expected 0", rs1_busy); end
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic test_collision();
        step();
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h0000_0009;
        step();
        req0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        n_chk++; if ({rf_w_en, rf_rd} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL coll_rf: got en=%b rd=%0d expected en=1 rd=9", rf_w_en, rf_rd); end
        step();
        issue_valid = 1'b0;
        #1;
        n_chk++; if (sb_busy[9] !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins: got %b expected 1", sb_busy[9]); end
    endtask

    task automatic test_reset_mid();
        // Two losses for requester 1 leave its counter at 2, then a transfer at T is cut by reset.
        step();
        req0_valid = 1'b1; req0_rd = 5'd6; req0_data = 32'h0000_0066;
        req1_valid = 1'b1; req1_rd = 5'd21; req1_data = 32'h0000_0021;
        step();                     // T
        #1;
        n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_grant: got %b expected 1", req0_ready); end
        step();                     // T+1
        rst = 1'b1;
        #1;
        n_chk++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ready_in_rst: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
        end
        n_chk++; if (rf_w_en !== 1'b1) begin n_fail++; $display("FAIL rmid_pending_wr: got %b expected 1", rf_w_en); end
        step();                     // T+2
        rst = 1'b0;
        #1;
        n_chk++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_dropped: got %b expected 0", rf_w_en); end
        n_chk++; if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL rmid_sb: got %h expected 0", sb_busy); end
        // Counter restarted at 0: requester 1 waits three full losses again.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            #1;
            n_chk++; if (req1_ready !== (i == 3) || req0_ready !== (i != 3)) begin
                n_fail++; $display("FAIL rmid_grant[%0d]: got r0=%b r1=%b expected r1=%b", i, req0_ready, req1_ready, (i == 3));
            end
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_req1_only();
        test_back_to_back();
        test_x0_filter();
        test_scoreboard();
        test_collision();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, is the number of consecutive lost arbitration cycles for requester 1 before it is forced a grant (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_rd  input  5  destination register of requester 0.
REQ-006 req0_data  input  32  write data of requester 0.
REQ-007 req0_ready  output  1  requester 0 granted this cycle; combinational.
REQ-008 req1_valid / req1_rd / req1_data / req1_ready  same widths and directions as REQ-004..007, for requester 1 (load/multicycle writeback).
REQ-009 rf_w_en  output  1  register-file write enable, registered.
REQ-010 rf_rd  output  5  register-file write address, registered.
REQ-011 rf_w_data  output  32  register-file write data, registered.
REQ-012 issue_valid  input  1  an instruction writing issue_rd is issued this cycle.
REQ-013 issue_rd  input  5  destination register of the issued instruction.
REQ-014 rs1 / rs2  input  5 each  source registers being checked for hazards.
REQ-015 rs1_busy / rs2_busy  output  1 each  source has an outstanding write; combinational from the scoreboard.
REQ-016 sb_busy  output  32  full scoreboard vector, bit n = register n pending.

Function
REQ-017 Handshake: a transfer occurs on reqN when reqN_valid and reqN_ready are both 1 in the same cycle.
REQ-018 Requesters hold valid, rd and data stable until the transfer; the arbiter does not check this.
REQ-019 At most one of req0_ready and req1_ready is 1 in any cycle.
REQ-020 If only one request is valid, that request is granted.
REQ-021 If neither request is valid, neither ready is asserted.
REQ-022 If both are valid, requester 0 is granted unless starve_cnt == STARVE_MAX, in which case requester 1 is granted.
REQ-023 starve_cnt is a 4-bit counter with the following update rule:
- increments when req1_valid=1 and req1 is not granted;
- saturates at STARVE_MAX;
- clears to 0 when req1 is granted or when req1_valid=0.
REQ-024 Write latency: a transfer in cycle T appears on rf_w_en/rf_rd/rf_w_data in cycle T+1, and the register file commits it at the end of T+1.
REQ-025 A transfer with rd=0 is accepted (ready=1) but produces rf_w_en=0 in T+1; rf_rd and rf_w_data still capture the granted values.
REQ-026 When there is no transfer in cycle T, rf_w_en=0 in T+1 and rf_rd/rf_w_data hold their previous values.
REQ-027 Back-to-back transfers sustain one write per cycle; the arbiter adds no bubbles.
REQ-028 Scoreboard set: on a clock edge with issue_valid=1 and issue_rd!=0, bit sb_busy[issue_rd] is set.
REQ-029 Scoreboard clear: on a clock edge with rf_w_en=1, bit sb_busy[rf_rd] is cleared, so the bit drops in the same cycle the register file holds the new value.
REQ-030 Simultaneous set and clear of the same bit: set wins, because a newer producer is outstanding.
REQ-031 Set and clear of different bits in the same cycle both take effect.
REQ-032 sb_busy[0] is constant 0; rsN_busy=0 whenever rsN=0.
REQ-033 rsN_busy = sb_busy[rsN], with no bypass of same-cycle set or clear.

Reset
REQ-034 While rst=1 at a clock edge, the following are cleared to 0: rf_w_en, rf_rd, rf_w_data, starve_cnt and sb_busy.
REQ-035 req0_ready and req1_ready are 0 in any cycle with rst=1, so no transfer is accepted during reset.
REQ-036 A write registered in the cycle before reset asserts is dropped: rf_w_en=0 in the first cycle after the reset edge.

Verification
REQ-037 Single requester: req0_valid=1, rd=5, data=0xDEADBEEF in cycle T -> req0_ready=1 in T; rf_w_en=1, rf_rd=5, rf_w_data=0xDEADBEEF in T+1; rf_w_en=0 in T+2.
REQ-038 Contention with STARVE_MAX=3 and both requests held valid (req0 re-presenting a new write each cycle) -> grants req0,req0,req0,req1,req0,...; starve_cnt reads 0,1,2,3,0.
REQ-039 x0 filter: req1_valid=1, rd=0 -> req1_ready=1; rf_w_en=0 next cycle; sb_busy unchanged.
REQ-040 Scoreboard lifecycle:
- issue_valid=1, issue_rd=7 at T -> sb_busy[7]=1 from T+1, and rs1=7 gives rs1_busy=1;
- req0 transfer with rd=7 at T+3 -> rf_w_en=1 at T+4, sb_busy[7]=0 from T+5.
REQ-041 Set/clear collision: rf_w_en=1 with rf_rd=9 while issue_valid=1, issue_rd=9 -> sb_busy[9] remains 1.
REQ-042 Reset mid-operation: transfer at T, rst=1 at T+1 -> rf_w_en=0 at T+2; sb_busy=0; starve_cnt=0; no ready asserted while rst=1.
